// File: rtl/spi_cmd_decoder.sv
`timescale 1ns/1ps
// spi_cmd_decoder: turns the byte stream from the SPI slave shifter into
// burst read/write requests on a req/ack memory bus. It also supplies the
// next transmit byte back to the shifter.
module spi_cmd_decoder #(
    parameter int         ADDR_W    = 24,
    parameter logic [7:0] CMD_WRITE = 8'h01,
    parameter logic [7:0] CMD_READ  = 8'h02,
    parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_cs_n,
    input  logic              spi_finished,
    input  logic [7:0]        spi_in_byte,
    output logic [7:0]        spi_out_byte,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack,
    output logic              overrun,
    output logic              underrun
);
    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD, ST_ADDR2, ST_ADDR1, ST_ADDR0, ST_WDATA, ST_RDATA, ST_IGNORE
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t            state_reg, state_next;
    logic              fin_sync1_reg, fin_sync2_reg, fin_hist_reg;
    logic              cs_sync1_reg, cs_sync2_reg;
    logic              byte_stb;
    logic              cmd_read_reg, cmd_read_next;
    logic [7:0]        addr_hi_reg, addr_hi_next;
    logic [7:0]        addr_mid_reg, addr_mid_next;
    logic [7:0]        rbuf_reg, rbuf_next;
    logic              rbuf_valid_reg, rbuf_valid_next;
    logic [7:0]        out_byte_reg, out_byte_next;
    logic              mem_req_reg, mem_req_next;
    logic              mem_we_reg, mem_we_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [7:0]        mem_wdata_reg, mem_wdata_next;
    logic              overrun_reg, overrun_next;
    logic              underrun_reg, underrun_next;

    // One-cycle pulse for every edge of the shifter's byte-complete toggle.
    assign byte_stb = fin_sync2_reg ^ fin_hist_reg;

    // Bring the finished toggle and chip select into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fin_sync1_reg <= 1'b0;
            fin_sync2_reg <= 1'b0;
            fin_hist_reg  <= 1'b0;
            cs_sync1_reg  <= 1'b0;
            cs_sync2_reg  <= 1'b0;
        end else begin
            fin_sync1_reg <= spi_finished;
            fin_sync2_reg <= fin_sync1_reg;
            fin_hist_reg  <= fin_sync2_reg;
            cs_sync1_reg  <= spi_cs_n;
            cs_sync2_reg  <= cs_sync1_reg;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            cmd_read_reg   <= 1'b0;
            addr_hi_reg    <= 8'h00;
            addr_mid_reg   <= 8'h00;
            rbuf_reg       <= 8'h00;
            rbuf_valid_reg <= 1'b0;
            out_byte_reg   <= IDLE_BYTE;
            mem_req_reg    <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= 8'h00;
            overrun_reg    <= 1'b0;
            underrun_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cmd_read_reg   <= cmd_read_next;
            addr_hi_reg    <= addr_hi_next;
            addr_mid_reg   <= addr_mid_next;
            rbuf_reg       <= rbuf_next;
            rbuf_valid_reg <= rbuf_valid_next;
            out_byte_reg   <= out_byte_next;
            mem_req_reg    <= mem_req_next;
            mem_we_reg     <= mem_we_next;
            mem_addr_reg   <= mem_addr_next;
            mem_wdata_reg  <= mem_wdata_next;
            overrun_reg    <= overrun_next;
            underrun_reg   <= underrun_next;
        end
    end

    // Next-state logic: the ack is folded in first, so a strobe in the same
    // cycle sees the cleared request (write) or the filled buffer (read).
    always_comb begin
        state_next      = state_reg;
        cmd_read_next   = cmd_read_reg;
        addr_hi_next    = addr_hi_reg;
        addr_mid_next   = addr_mid_reg;
        rbuf_next       = rbuf_reg;
        rbuf_valid_next = rbuf_valid_reg;
        out_byte_next   = out_byte_reg;
        mem_req_next    = mem_req_reg;
        mem_we_next     = mem_we_reg;
        mem_addr_next   = mem_addr_reg;
        mem_wdata_next  = mem_wdata_reg;
        overrun_next    = overrun_reg;
        underrun_next   = underrun_reg;

        // A request is completed even after chip select drops.
        if (mem_ack && mem_req_reg) begin
            mem_req_next = 1'b0;
            if (mem_we_reg) begin
                mem_addr_next = mem_addr_reg + ADDR_ONE;
            end else begin
                rbuf_next       = mem_rdata;
                rbuf_valid_next = 1'b1;
            end
        end

        if (cs_sync2_reg) begin
            state_next    = ST_IDLE;
            out_byte_next = IDLE_BYTE;
        end else begin
            case (state_reg)
                ST_IDLE: state_next = ST_CMD;
                ST_CMD: begin
                    if (byte_stb) begin
                        if (spi_in_byte == CMD_WRITE) begin
                            cmd_read_next = 1'b0;
                            state_next    = ST_ADDR2;
                        end else if (spi_in_byte == CMD_READ) begin
                            cmd_read_next = 1'b1;
                            state_next    = ST_ADDR2;
                        end else begin
                            state_next = ST_IGNORE;
                        end
                    end
                end
                ST_ADDR2: begin
                    if (byte_stb) begin
                        addr_hi_next = spi_in_byte;
                        state_next   = ST_ADDR1;
                    end
                end
                ST_ADDR1: begin
                    if (byte_stb) begin
                        addr_mid_next = spi_in_byte;
                        state_next    = ST_ADDR0;
                    end
                end
                ST_ADDR0: begin
                    if (byte_stb) begin
                        mem_addr_next = ADDR_W'({addr_hi_reg, addr_mid_reg, spi_in_byte});
                        if (cmd_read_reg) begin
                            // Prefetch the first word while the dummy byte goes by.
                            mem_req_next    = 1'b1;
                            mem_we_next     = 1'b0;
                            rbuf_valid_next = 1'b0;
                            state_next      = ST_RDATA;
                        end else begin
                            state_next = ST_WDATA;
                        end
                    end
                end
                ST_WDATA: begin
                    if (byte_stb) begin
                        if (mem_req_next) begin
                            overrun_next = 1'b1;
                        end else begin
                            mem_wdata_next = spi_in_byte;
                            mem_we_next    = 1'b1;
                            mem_req_next   = 1'b1;
                        end
                    end
                end
                ST_RDATA: begin
                    if (byte_stb) begin
                        if (rbuf_valid_next) begin
                            out_byte_next   = rbuf_next;
                            rbuf_valid_next = 1'b0;
                            mem_addr_next   = mem_addr_next + ADDR_ONE;
                            mem_req_next    = 1'b1;
                            mem_we_next     = 1'b0;
                        end else begin
                            out_byte_next = IDLE_BYTE;
                            underrun_next = 1'b1;
                        end
                    end
                end
                ST_IGNORE: out_byte_next = IDLE_BYTE;
                default:   state_next = ST_IDLE;
            endcase
        end
    end

    assign spi_out_byte = out_byte_reg;
    assign mem_req      = mem_req_reg;
    assign mem_we       = mem_we_reg;
    assign mem_addr     = mem_addr_reg;
    assign mem_wdata    = mem_wdata_reg;
    assign overrun      = overrun_reg;
    assign underrun     = underrun_reg;
endmodule

// File: tb/tb_spi_cmd_decoder.sv
`timescale 1ns/1ps
// Testbench for spi_cmd_decoder: drives whole SPI transactions byte by byte
// and predicts the bus traffic and transmit bytes from the command rules.
module tb_spi_cmd_decoder;
    logic        clk, rst, spi_cs_n, spi_finished;
    logic [7:0]  spi_in_byte, spi_out_byte, mem_wdata, mem_rdata;
    logic        mem_req, mem_we, mem_ack, overrun, underrun;
    logic [23:0] mem_addr;

    typedef struct packed { logic we; logic [23:0] addr; logic [7:0] data; } hs_t;
    hs_t         got_q[$];
    hs_t         exp_q[$];
    hs_t         last_hs[$];
    logic [7:0]  last_tx[$];
    logic [7:0]  txq[$];
    logic [7:0]  mem_model [logic [23:0]];
    int          errors = 0;
    int          checks = 0;
    int          ack_lat = 1;
    bit          ack_en = 1;
    bit          exp_overrun = 0;
    bit          exp_underrun = 0;
    bit          req_seen = 0;

    spi_cmd_decoder dut (
        .clk(clk), .rst(rst), .spi_cs_n(spi_cs_n), .spi_finished(spi_finished),
        .spi_in_byte(spi_in_byte), .spi_out_byte(spi_out_byte),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .overrun(overrun), .underrun(underrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory contents: written bytes, otherwise a fixed address pattern.
    function automatic logic [7:0] mem_rd(input logic [23:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return 8'(a[7:0] * 8'd7 + a[15:8] + a[23:16] + 8'h35);
    endfunction

    // Memory responder: acks ack_lat cycles after the request, logs each handshake.
    initial begin
        int  lat_cnt;
        hs_t h;
        mem_ack = 1'b0; mem_rdata = 8'h00; lat_cnt = 0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_req && !rst && ack_en) begin
                if (lat_cnt >= ack_lat) begin
                    h.we = mem_we; h.addr = mem_addr;
                    if (mem_we) begin
                        h.data = mem_wdata;
                        mem_model[mem_addr] = mem_wdata;
                    end else begin
                        h.data = mem_rd(mem_addr);
                        mem_rdata = h.data;
                    end
                    got_q.push_back(h);
                    mem_ack = 1'b1;
                    lat_cnt = 0;
                end else begin
                    lat_cnt++;
                end
            end else begin
                lat_cnt = 0;
            end
        end
    end

    // Per-cycle rules: a request only drops on an ack, error flags never clear.
    initial begin
        logic prev_req, prev_ov, prev_un, ack_s, rst_s;
        prev_req = 1'b0; prev_ov = 1'b0; prev_un = 1'b0;
        forever begin
            @(posedge clk);
            ack_s = mem_ack; rst_s = rst;
            #1;
            if (mem_req) req_seen = 1'b1;
            if (!rst_s && !rst) begin
                if (prev_req && !mem_req) check("req_drop_without_ack", ack_s, 1'b1);
                if (prev_ov) check("overrun_sticky", overrun, 1'b1);
                if (prev_un) check("underrun_sticky", underrun, 1'b1);
            end
            prev_req = mem_req; prev_ov = overrun; prev_un = underrun;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        spi_in_byte  = b;
        spi_finished = ~spi_finished;
        repeat ($urandom_range(64, 100)) @(negedge clk);
    endtask

    task automatic wait_req_drop();
        for (int k = 0; k < 300 && mem_req; k++) @(negedge clk);
        check("req_released", mem_req, 1'b0);
    endtask

    task automatic compare_hs();
        check("hs_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got_q.size()) check($sformatf("hs[%0d]", i), got_q[i], exp_q[i]);
        last_hs = got_q;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_outputs();
        check("rst_out_byte", spi_out_byte, 8'hFF);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 24'h0);
        check("rst_mem_wdata", mem_wdata, 8'h00);
        check("rst_overrun", overrun, 1'b0);
        check("rst_underrun", underrun, 1'b0);
    endtask

    // Runs txq as one chip-select frame and checks it against the command rules.
    task automatic run_txn();
        int          n;
        logic [23:0] a;
        logic [7:0]  exp_out[$];
        n = txq.size();
        a = 24'h0;
        if (n >= 4) a = {txq[1], txq[2], txq[3]};
        for (int j = 0; j < n; j++)
            exp_out.push_back((txq[0] == 8'h02 && j >= 4) ? mem_rd(a + 24'(j - 4)) : 8'hFF);
        if (txq[0] == 8'h01)
            for (int i = 4; i < n; i++) exp_q.push_back(hs_t'({1'b1, a + 24'(i - 4), txq[i]}));
        if (txq[0] == 8'h02 && n >= 4)
            for (int i = 4; i <= n; i++)
                exp_q.push_back(hs_t'({1'b0, a + 24'(i - 4), mem_rd(a + 24'(i - 4))}));
        last_tx.delete();
        spi_cs_n = 1'b0;
        repeat (6) @(negedge clk);
        for (int j = 0; j < n; j++) begin
            send_byte(txq[j]);
            last_tx.push_back(spi_out_byte);
            check($sformatf("tx_byte[%0d]", j), spi_out_byte, exp_out[j]);
        end
        spi_cs_n = 1'b1;
        repeat (4) @(negedge clk);
        check("tx_idle_after_cs", spi_out_byte, 8'hFF);
        wait_req_drop();
        compare_hs();
        check("overrun_flag", overrun, exp_overrun);
        check("underrun_flag", underrun, exp_underrun);
        repeat (4) @(negedge clk);
    endtask

    task automatic load_txn(input int n, input logic [63:0] pk);
        txq.delete();
        for (int i = 0; i < n; i++) txq.push_back(pk[8*(n-1-i) +: 8]);
    endtask

    task automatic pin_hs(input int i, input logic [32:0] exp);
        checks++;
        if (i >= last_hs.size() || last_hs[i] !== exp) begin
            errors++;
            $display("FAIL pin_hs[%0d]: got %h expected %h", i,
                     (i < last_hs.size()) ? last_hs[i] : 33'h0, exp);
        end
    endtask

    initial begin
        logic [7:0] d1, d2;
        rst = 1'b1; spi_cs_n = 1'b1; spi_finished = 1'b0; spi_in_byte = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Burst write of two bytes.
        load_txn(6, 64'h01_12_34_56_AA_BB);
        run_txn();
        pin_hs(0, {1'b1, 24'h123456, 8'hAA});
        pin_hs(1, {1'b1, 24'h123457, 8'hBB});

        // Burst read: dummy byte, then the three stored bytes come back.
        mem_model[24'h0010FE] = 8'h11;
        mem_model[24'h0010FF] = 8'h22;
        mem_model[24'h001100] = 8'h33;
        load_txn(8, 64'h02_00_10_FE_00_5A_5A_5A);
        run_txn();
        check("pin_rd0", last_tx[4], 8'h11);
        check("pin_rd1", last_tx[5], 8'h22);
        check("pin_rd2", last_tx[6], 8'h33);

        // Unknown command: nothing on the bus.
        req_seen = 1'b0;
        load_txn(5, 64'h7E_01_02_03_04);
        run_txn();
        check("ignore_no_req", req_seen, 1'b0);

        // Read across the top of the address space.
        load_txn(7, 64'h02_FF_FF_FF_00_00_00);
        run_txn();
        pin_hs(0, {1'b0, 24'hFFFFFF, mem_rd(24'hFFFFFF)});
        pin_hs(1, {1'b0, 24'h000000, mem_rd(24'h000000)});
        pin_hs(2, {1'b0, 24'h000001, mem_rd(24'h000001)});

        // Randomized frames with random memory latency.
        for (int r = 0; r < 10; r++) begin
            int n, sel;
            n = $urandom_range(1, 8);
            sel = $urandom_range(0, 3);
            ack_lat = $urandom_range(0, 6);
            txq.delete();
            txq.push_back(sel < 2 ? 8'h01 : (sel == 2 ? 8'h02 : 8'($urandom_range(0, 255))));
            for (int i = 1; i < n; i++) txq.push_back(8'($urandom));
            run_txn();
        end
        ack_lat = 1;

        // Overrun: ack withheld across two write bytes, second one is dropped.
        d1 = 8'($urandom); d2 = 8'($urandom);
        ack_en = 1'b0;
        spi_cs_n = 1'b0;
        repeat (6) @(negedge clk);
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h40);
        send_byte(d1);
        check("ovr_req_pending", mem_req, 1'b1);
        check("ovr_flag_clear", overrun, 1'b0);
        send_byte(d2);
        check("ovr_flag_set", overrun, 1'b1);
        check("ovr_wdata_kept", mem_wdata, d1);
        spi_cs_n = 1'b1;
        repeat (6) @(negedge clk);
        check("ovr_req_held_cs", mem_req, 1'b1);
        check("ovr_sticky_cs", overrun, 1'b1);
        ack_en = 1'b1;
        wait_req_drop();
        exp_q.push_back(hs_t'({1'b1, 24'h000040, d1}));
        compare_hs();
        exp_overrun = 1'b1;

        // Underrun: data not ready for the dummy byte, address must not advance.
        mem_model[24'h000080] = 8'h3C;
        mem_model[24'h000081] = 8'hC3;
        ack_en = 1'b0;
        spi_cs_n = 1'b0;
        repeat (6) @(negedge clk);
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h80);
        send_byte(8'h00);
        check("udr_tx_idle", spi_out_byte, 8'hFF);
        check("udr_flag_set", underrun, 1'b1);
        check("udr_addr_hold", mem_addr, 24'h000080);
        ack_en = 1'b1;
        repeat (20) @(negedge clk);
        send_byte(8'h00);
        check("udr_tx_a", spi_out_byte, 8'h3C);
        send_byte(8'h00);
        check("udr_tx_b", spi_out_byte, 8'hC3);
        spi_cs_n = 1'b1;
        repeat (4) @(negedge clk);
        wait_req_drop();
        exp_q.push_back(hs_t'({1'b0, 24'h000080, 8'h3C}));
        exp_q.push_back(hs_t'({1'b0, 24'h000081, 8'hC3}));
        exp_q.push_back(hs_t'({1'b0, 24'h000082, mem_rd(24'h000082)}));
        compare_hs();
        exp_underrun = 1'b1;

        // Chip select dropped in the address phase.
        spi_cs_n = 1'b0;
        repeat (6) @(negedge clk);
        send_byte(8'h01); send_byte(8'h12);
        spi_cs_n = 1'b1;
        repeat (6) @(negedge clk);
        check("cs_abort_no_req", mem_req, 1'b0);
        check("cs_abort_tx", spi_out_byte, 8'hFF);

        // Chip select dropped with a write pending: the request is still completed.
        d1 = 8'($urandom);
        ack_en = 1'b0;
        spi_cs_n = 1'b0;
        repeat (6) @(negedge clk);
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h20);
        send_byte(d1);
        spi_cs_n = 1'b1;
        repeat (6) @(negedge clk);
        check("cs_req_held", mem_req, 1'b1);
        ack_en = 1'b1;
        wait_req_drop();
        exp_q.push_back(hs_t'({1'b1, 24'h000020, d1}));
        compare_hs();

        // Reset with a write pending: everything clears at once.
        ack_en = 1'b0;
        spi_cs_n = 1'b0;
        repeat (6) @(negedge clk);
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h30);
        send_byte(8'h77);
        check("rst_req_pending", mem_req, 1'b1);
        #2 rst = 1'b1;
        #1 check_reset_outputs();
        spi_cs_n = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_overrun = 1'b0; exp_underrun = 1'b0;
        ack_en = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_no_handshake", got_q.size(), 0);

        // Decoding still works after the reset.
        load_txn(6, 64'h01_AB_CD_EF_42_43);
        run_txn();
        pin_hs(1, {1'b1, 24'hABCDF0, 8'h43});
        load_txn(6, 64'h02_AB_CD_EF_00_00);
        run_txn();
        check("post_rst_rd", last_tx[4], 8'h42);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
